lsu_align_ctrl: RTL and testbench



---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_align_ctrl_if.sv | 32 +++
 rtl/lsu_lane_align.sv | 39 +++
 rtl/lsu_align_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_lsu_align_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment sequencer: memop codes, FSM
// states and the size/lane-mask helpers.
package lsu_pkg;

    localparam logic [2:0] MemopB  = 3'b000;
    localparam logic [2:0] MemopH  = 3'b001;
    localparam logic [2:0] MemopW  = 3'b010;
    localparam logic [2:0] MemopBu = 3'b100;
    localparam logic [2:0] MemopHu = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StAcc0,
        StAcc1,
        StLwait,
        StResp
    } lsu_state_e;

    // Access size in bytes; illegal codes behave as full-word accesses.
    function automatic logic [2:0] memop_size(input logic [2:0] memop);
        logic [2:0] size;
        case (memop[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
        return size;
    endfunction

    // Unshifted byte-lane mask for a store; illegal codes write nothing.
    function automatic logic [3:0] memop_basemask(input logic [2:0] memop);
        logic [3:0] mask;
        case (memop)
            MemopB, MemopBu: mask = 4'b0001;
            MemopH, MemopHu: mask = 4'b0011;
            MemopW:          mask = 4'b1111;
            default:         mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // True when the access runs past the end of its word.
    function automatic logic needs_split(input logic [1:0] off, input logic [2:0] memop);
        logic [3:0] span;
        span = 4'(off) + 4'(memop_size(memop));
        return span > 4'd4;
    endfunction

endpackage

// File: rtl/lsu_align_ctrl_if.sv
// CPU request/response and data-RAM port bundle for lsu_align_ctrl.
// slave = the sequencer's view, master = the CPU/RAM environment's view.
interface lsu_align_ctrl_if #(
    parameter int unsigned ADDR_W = 15
) ();
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [2:0]        req_memop;
    logic              req_we;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_addr, req_memop, req_we, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_we, mem_wmask, mem_wdata
    );

    modport master (
        output req_valid, req_addr, req_memop, req_we, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_we, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data/mask shift across two words and
// load merge with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  memop_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_lo_data_o,
    output logic [31:0] st_hi_data_o,
    output logic [3:0]  st_lo_mask_o,
    output logic [3:0]  st_hi_mask_o,
    input  logic [31:0] ld_word0_i,
    input  logic [31:0] ld_word1_i,
    output logic [31:0] ld_data_o
);
    logic [63:0] st_wide;
    logic [7:0]  mask_wide;
    logic [31:0] merged;

    // Shift store data/mask to their lanes and extract/extend load data.
    always_comb begin
        st_wide      = {32'h0, st_data_i} << {off_i, 3'b000};
        mask_wide    = {4'h0, memop_basemask(memop_i)} << off_i;
        st_lo_data_o = st_wide[31:0];
        st_hi_data_o = st_wide[63:32];
        st_lo_mask_o = mask_wide[3:0];
        st_hi_mask_o = mask_wide[7:4];

        merged = 32'({ld_word1_i, ld_word0_i} >> {off_i, 3'b000});
        case (memop_i)
            MemopB:  ld_data_o = {{24{merged[7]}}, merged[7:0]};
            MemopH:  ld_data_o = {{16{merged[15]}}, merged[15:0]};
            MemopBu: ld_data_o = {24'h0, merged[7:0]};
            MemopHu: ld_data_o = {16'h0, merged[15:0]};
            default: ld_data_o = merged;
        endcase
    end
endmodule

// File: rtl/lsu_align_ctrl.sv
// Load/store sequencer in front of a byte-enabled, 1-cycle-read data RAM.
// Handles one request at a time, splitting word-crossing accesses in two.
// Optional build macro LSU_MISALIGN_TRAP_EN: word-crossing accesses are not
// split but answered immediately with rsp_err=1.
module lsu_align_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 15
) (
    input  logic            clk,
    input  logic            rst,
    lsu_align_ctrl_if.slave bus
);
    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        memop_q, memop_d;
    logic              we_q, we_d;
    logic              split_q, split_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word0_q, word0_d;

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic [ADDR_W-1:0] req_word;
    logic              req_split;
    logic              trap_hit;
    logic [2:0]        al_memop;
    logic [1:0]        al_off;
    logic [31:0]       al_wdata;
    logic [31:0]       al_word0;
    logic [31:0]       st_lo_data, st_hi_data, ld_data;
    logic [3:0]        st_lo_mask, st_hi_mask;
    logic              unused_addr_hi;

    assign req_word       = bus.req_addr[ADDR_W+1:2];
    assign req_split      = needs_split(bus.req_addr[1:0], bus.req_memop);
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_hit = req_split;
`else
    assign trap_hit = 1'b0;
`endif

    // Lane logic sees the live request in IDLE (to prepare ACC0) and the latched one after.
    always_comb begin
        if (state_q == StIdle) begin
            al_memop = bus.req_memop;
            al_off   = bus.req_addr[1:0];
            al_wdata = bus.req_wdata;
        end else begin
            al_memop = memop_q;
            al_off   = off_q;
            al_wdata = wdata_q;
        end
        al_word0 = split_q ? word0_q : bus.mem_rdata;
    end

    lsu_lane_align u_lane_align (
        .memop_i      (al_memop),
        .off_i        (al_off),
        .st_data_i    (al_wdata),
        .st_lo_data_o (st_lo_data),
        .st_hi_data_o (st_hi_data),
        .st_lo_mask_o (st_lo_mask),
        .st_hi_mask_o (st_hi_mask),
        .ld_word0_i   (al_word0),
        .ld_word1_i   (bus.mem_rdata),
        .ld_data_o    (ld_data)
    );

    // Next state, request latches and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        off_d       = off_q;
        memop_d     = memop_q;
        we_d        = we_q;
        split_d     = split_q;
        wdata_d     = wdata_q;
        word0_d     = word0_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wmask_d = 4'h0;
        mem_wdata_d = 32'h0;

        unique case (state_q)
            StIdle: begin
                req_ready_d = 1'b1;
                if (bus.req_valid) begin
                    req_ready_d = 1'b0;
                    word_d      = req_word;
                    off_d       = bus.req_addr[1:0];
                    memop_d     = bus.req_memop;
                    we_d        = bus.req_we;
                    split_d     = req_split;
                    wdata_d     = bus.req_wdata;
                    if (trap_hit) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d    = StAcc0;
                        mem_addr_d = req_word;
                        if (bus.req_we) begin
                            mem_we_d    = 1'b1;
                            mem_wmask_d = st_lo_mask;
                            mem_wdata_d = st_lo_data;
                        end
                    end
                end
            end
            StAcc0: begin
                if (split_q) begin
                    state_d    = StAcc1;
                    mem_addr_d = word_q + 1'b1;   // wraps modulo 2^ADDR_W
                    if (we_q) begin
                        mem_we_d    = 1'b1;
                        mem_wmask_d = st_hi_mask;
                        mem_wdata_d = st_hi_data;
                    end
                end else if (!we_q) begin
                    state_d = StLwait;
                end else begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                end
            end
            StAcc1: begin
                word0_d = bus.mem_rdata;
                if (!we_q) begin
                    state_d = StLwait;
                end else begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                end
            end
            StLwait: begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ld_data;
            end
            StResp: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // FSM state, request latches and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            word_q      <= '0;
            off_q       <= 2'b00;
            memop_q     <= 3'b000;
            we_q        <= 1'b0;
            split_q     <= 1'b0;
            wdata_q     <= 32'h0;
            word0_q     <= 32'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= 4'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            off_q       <= off_d;
            memop_q     <= memop_d;
            we_q        <= we_d;
            split_q     <= split_d;
            wdata_q     <= wdata_d;
            word0_q     <= word0_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wmask_q <= mem_wmask_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wmask = mem_wmask_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Directed bench for lsu_align_ctrl with a behavioural byte-enabled RAM.
module tb_lsu_align_ctrl;
    localparam int unsigned AW = 15;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    mask;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;
    logic [31:0]   ram [0:(1<<AW)-1];
    logic [31:0]   wr_word;
    wr_t           wlog [$];

    lsu_align_ctrl_if #(.ADDR_W(AW)) bus ();

    lsu_align_ctrl #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RAM: synchronous read (old data), byte-masked write, write log for checking.
    always @(posedge clk) begin
        bus.mem_rdata <= ram[bus.mem_addr];
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (bus.mem_we) begin
            wr_word = ram[bus.mem_addr];
            for (int b = 0; b < 4; b++)
                if (bus.mem_wmask[b]) wr_word[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            ram[bus.mem_addr] <= wr_word;
            wlog.push_back({bus.mem_addr, bus.mem_wmask, bus.mem_wdata});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // One request; lat = cycles from acceptance to rsp_valid (0 = none within budget).
    task automatic run_req(input logic [31:0] addr, input logic [2:0] op, input logic we,
                           input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                           output logic err, output logic [AW-1:0] a1, output logic [AW-1:0] a2,
                           output logic rdy);
        @(negedge clk);
        rdy           = bus.req_ready;
        wlog.delete();
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_memop = op;
        bus.req_we    = we;
        bus.req_wdata = wd;
        lat   = 0;
        rdata = 32'hDEAD_BEEF;
        err   = 1'bx;
        a1    = '0;
        a2    = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.req_valid = 1'b0;
                a1 = bus.mem_addr;
            end
            if (n == 2) a2 = bus.mem_addr;
            if (bus.rsp_valid) begin
                lat   = n;
                rdata = bus.rsp_rdata;
                err   = bus.rsp_err;
                break;
            end
        end
    endtask

    int            lat;
    logic [31:0]   rd;
    logic          er;
    logic [AW-1:0] a1, a2;
    logic          rdy;
    logic          saw_rsp;

    initial begin
        rst           = 1'b1;
        pl_en         = 1'b0;
        pl_addr       = '0;
        pl_data       = 32'h0;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_memop = 3'b000;
        bus.req_we    = 1'b0;
        bus.req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err",   bus.rsp_err, 0);
        chk("rst_mem_we",    bus.mem_we, 0);
        chk("rst_mem_wmask", bus.mem_wmask, 0);
        chk("rst_mem_addr",  bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        preload(15'd4, 32'h4433_2211);
        preload(15'd5, 32'h8877_6655);
        rst = 1'b0;

        // lw 0x10: aligned
        run_req(32'h10, 3'b010, 1'b0, 32'h0, lat, rd, er, a1, a2, rdy);
        chk("lw10_ready", rdy, 1);
        chk("lw10_lat", lat, 3);
        chk("lw10_rdata", rd, 32'h4433_2211);
        chk("lw10_err", er, 0);
        chk("lw10_addr", a1, 4);
        chk("lw10_nowrite", wlog.size(), 0);
        @(negedge clk);
        chk("lw10_rsp_pulse", bus.rsp_valid, 0);

        // lw 0x13: split
        run_req(32'h13, 3'b010, 1'b0, 32'h0, lat, rd, er, a1, a2, rdy);
        chk("lw13_lat", lat, Trap ? 1 : 4);
        chk("lw13_rdata", rd, Trap ? 32'h0 : 32'h7766_5544);
        chk("lw13_err", er, Trap);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("lw13_addr0", a1, 4);
        chk("lw13_addr1", a2, 5);
`endif

        run_req(32'h13, 3'b001, 1'b0, 32'h0, lat, rd, er, a1, a2, rdy);
        chk("lh13_lat", lat, Trap ? 1 : 4);
        chk("lh13_rdata", rd, Trap ? 32'h0 : 32'h0000_5544);

        run_req(32'h17, 3'b000, 1'b0, 32'h0, lat, rd, er, a1, a2, rdy);
        chk("lb17_lat", lat, 3);
        chk("lb17_rdata", rd, 32'hFFFF_FF88);

        run_req(32'h17, 3'b100, 1'b0, 32'h0, lat, rd, er, a1, a2, rdy);
        chk("lbu17_rdata", rd, 32'h0000_0088);

        run_req(32'h16, 3'b101, 1'b0, 32'h0, lat, rd, er, a1, a2, rdy);
        chk("lhu16_lat", lat, 3);
        chk("lhu16_rdata", rd, 32'h0000_8877);

        // sw 0x12: split store
        run_req(32'h12, 3'b010, 1'b1, 32'hAABB_CCDD, lat, rd, er, a1, a2, rdy);
        chk("sw12_lat", lat, Trap ? 1 : 3);
        chk("sw12_rdata", rd, 0);
        chk("sw12_err", er, Trap);
        chk("sw12_nwr", wlog.size(), Trap ? 0 : 2);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("sw12_w0", wlog[0], {15'd4, 4'b1100, 32'hCCDD_0000});
        chk("sw12_w1", wlog[1], {15'd5, 4'b0011, 32'h0000_AABB});
`endif
        run_req(32'h10, 3'b010, 1'b0, 32'h0, lat, rd, er, a1, a2, rdy);
        chk("sw12_rb4", rd, Trap ? 32'h4433_2211 : 32'hCCDD_2211);
        run_req(32'h14, 3'b010, 1'b0, 32'h0, lat, rd, er, a1, a2, rdy);
        chk("sw12_rb5", rd, Trap ? 32'h8877_6655 : 32'h8877_AABB);

        // sb 0x21: aligned byte store
        run_req(32'h21, 3'b000, 1'b1, 32'h0000_005A, lat, rd, er, a1, a2, rdy);
        chk("sb21_lat", lat, 2);
        chk("sb21_nwr", wlog.size(), 1);
        chk("sb21_w0", wlog[0], {15'd8, 4'b0010, 32'h0000_5A00});

        // Illegal store: responds, writes nothing
        run_req(32'h10, 3'b011, 1'b1, 32'hFFFF_FFFF, lat, rd, er, a1, a2, rdy);
        chk("ilst_lat", lat, 2);
        chk("ilst_mask", wlog[0].mask, 0);
        run_req(32'h10, 3'b010, 1'b0, 32'h0, lat, rd, er, a1, a2, rdy);
        chk("ilst_rb", rd, Trap ? 32'h4433_2211 : 32'hCCDD_2211);

        // Illegal load: full word
        run_req(32'h14, 3'b111, 1'b0, 32'h0, lat, rd, er, a1, a2, rdy);
        chk("illd_lat", lat, 3);
        chk("illd_rdata", rd, Trap ? 32'h8877_6655 : 32'h8877_AABB);

        // Word-address wrap: sh 0x1FFFF
        run_req(32'h0001_FFFF, 3'b001, 1'b1, 32'h0000_1234, lat, rd, er, a1, a2, rdy);
        chk("wrap_lat", lat, Trap ? 1 : 3);
        chk("wrap_err", er, Trap);
        chk("wrap_nwr", wlog.size(), Trap ? 0 : 2);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("wrap_w0", wlog[0], {15'h7FFF, 4'b1000, 32'h3400_0000});
        chk("wrap_w1", wlog[1], {15'h0000, 4'b0001, 32'h0000_0012});
`endif

        // Reset during ACC1 of a split store
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h12;
        bus.req_memop = 3'b010;
        bus.req_we    = 1'b1;
        bus.req_wdata = 32'h1122_3344;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("rstacc1_addr", bus.mem_addr, 5);
        chk("rstacc1_we", bus.mem_we, 1);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstacc1_ready", bus.req_ready, 1);
        chk("rstacc1_mem_we", bus.mem_we, 0);
        chk("rstacc1_rsp", bus.rsp_valid, 0);
        saw_rsp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid) saw_rsp = 1'b1;
        end
        chk("rstacc1_no_rsp", saw_rsp, 0);
        run_req(32'h10, 3'b010, 1'b0, 32'h0, lat, rd, er, a1, a2, rdy);
        chk("post_rst_ready", rdy, 1);
        chk("post_rst_lat", lat, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
